// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core's
// load/store port and one external master. The core wins by default; an
// external master denied STARVE_LIMIT consecutive cycles gets one forced
// cycle, during which the core is stalled, followed by a guard cycle that
// always lets the core through.
module dmem_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    // core load/store port
    input  logic          c_W_en,
    input  logic          c_R_en,
    input  logic [AW-1:0] c_addr,
    input  logic [2:0]    c_RW_type,
    input  logic [DW-1:0] c_din,
    output logic [DW-1:0] c_dout,
    output logic          c_stall,
    // external master port
    input  logic          e_req,
    input  logic          e_we,
    input  logic [AW-1:0] e_addr,
    input  logic [2:0]    e_RW_type,
    input  logic [DW-1:0] e_din,
    output logic          e_gnt,
    output logic          e_rvalid,
    output logic [DW-1:0] e_rdata,
    // memory side
    output logic          m_W_en,
    output logic          m_R_en,
    output logic [AW-1:0] m_addr,
    output logic [2:0]    m_RW_type,
    output logic [DW-1:0] m_din,
    input  logic [DW-1:0] m_dout
);

    localparam int            CW       = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STARVE_LIMIT - 1);

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        FORCE  = 2'd1,
        GUARD  = 2'd2
    } state_t;

    state_t        state, state_nxt, state_eff;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          core_active;

    assign core_active = c_W_en | c_R_en;
    assign c_dout      = m_dout;

    // Arbitration decision and next-state logic.
    always_comb begin
        // NOTE: every output of this block gets a default before the case so
        // no path leaves a signal unassigned, which would infer a latch.
        // While rst_n is low the outputs already behave as in NORMAL, so a
        // reset landing on a forced cycle never stalls the core.
        state_eff = rst_n ? state : NORMAL;
        e_gnt     = e_req & ~core_active;
        c_stall   = 1'b0;
        state_nxt = state_eff;
        cnt_nxt   = '0;
        case (state_eff)
            NORMAL: begin
                if (e_req & core_active) begin
                    if (cnt == CNT_LAST) begin
                        state_nxt = FORCE;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            FORCE: begin
                e_gnt     = e_req;
                // Stall only when the forced grant actually takes the memory;
                // a withdrawn request leaves the core running.
                c_stall   = e_req & core_active;
                state_nxt = e_req ? GUARD : NORMAL;
            end
            GUARD: begin
                state_nxt = NORMAL;
            end
            default: begin
                state_nxt = NORMAL;
            end
        endcase
    end

    // State and starvation counter registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (!rst_n) begin
            state <= NORMAL;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Memory-side mux: external master when granted, otherwise the core.
    always_comb begin
        if (e_gnt) begin
            m_W_en    = e_we;
            m_R_en    = ~e_we;
            m_addr    = e_addr;
            m_RW_type = e_RW_type;
            m_din     = e_din;
        end else begin
            m_W_en    = c_W_en & ~c_stall;
            m_R_en    = c_R_en & ~c_stall;
            m_addr    = c_addr;
            m_RW_type = c_RW_type;
            m_din     = c_din;
        end
    end

    // Registered read return for the external master.
    always_ff @(posedge clk) begin
        // NOTE: e_rdata is a single register (not a memory array), so it is
        // cleared on reset to give a known value after reset.
        if (!rst_n) begin
            e_rvalid <= 1'b0;
            e_rdata  <= '0;
        end else begin
            e_rvalid <= e_gnt & ~e_we;
            if (e_gnt & ~e_we) begin
                e_rdata <= m_dout;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed test-plan scenarios followed by
// randomized traffic, checked against a streak-counting reference model and
// a scoreboard for external read returns.
module tb_dmem_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          c_W_en, c_R_en;
    logic [AW-1:0] c_addr;
    logic [2:0]    c_RW_type;
    logic [DW-1:0] c_din, c_dout;
    logic          c_stall;
    logic          e_req, e_we;
    logic [AW-1:0] e_addr;
    logic [2:0]    e_RW_type;
    logic [DW-1:0] e_din;
    logic          e_gnt, e_rvalid;
    logic [DW-1:0] e_rdata;
    logic          m_W_en, m_R_en;
    logic [AW-1:0] m_addr;
    logic [2:0]    m_RW_type;
    logic [DW-1:0] m_din, m_dout;

    int compared   = 0;
    int mismatched = 0;

    dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_W_en(c_W_en), .c_R_en(c_R_en), .c_addr(c_addr), .c_RW_type(c_RW_type),
        .c_din(c_din), .c_dout(c_dout), .c_stall(c_stall),
        .e_req(e_req), .e_we(e_we), .e_addr(e_addr), .e_RW_type(e_RW_type),
        .e_din(e_din), .e_gnt(e_gnt), .e_rvalid(e_rvalid), .e_rdata(e_rdata),
        .m_W_en(m_W_en), .m_R_en(m_R_en), .m_addr(m_addr), .m_RW_type(m_RW_type),
        .m_din(m_din), .m_dout(m_dout)
    );

    always #5 clk = ~clk;

    // Data memory stand-in: combinational read, write at the rising edge.
    logic [31:0] mem [256] = '{16: 32'hDEADBEEF, 68: 32'h0BADF00D, default: 32'h0};
    always @(posedge clk) if (m_W_en) mem[m_addr[7:0]] <= m_din;
    assign m_dout = mem[m_addr[7:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // The external master is owed a cycle once it has been refused LIMIT
    // cycles in a row; the cycle after a used forced cycle cannot be forced
    // and does not count as a refusal.
    logic [31:0] ref_mem [256] = '{16: 32'hDEADBEEF, 68: 32'h0BADF00D, default: 32'h0};
    logic [31:0] sb_q [$];
    int          denied   = 0;
    bit          after_fg = 1'b0;
    bit          ca, forced, x_gnt, x_stall;

    always @(negedge clk) begin
        ca      = c_W_en | c_R_en;
        forced  = rst_n && !after_fg && (denied >= LIMIT);
        x_gnt   = forced ? e_req : (e_req & !ca);
        x_stall = forced & e_req & ca;

        check("gnt", e_gnt, x_gnt);
        check("stall", c_stall, x_stall);
        if (x_gnt) begin
            check("m_en", {m_W_en, m_R_en, m_RW_type}, {e_we, !e_we, e_RW_type});
            check("m_addr", m_addr, e_addr);
            check("m_din", m_din, e_din);
        end else begin
            check("m_en", {m_W_en, m_R_en, m_RW_type}, {c_W_en & !x_stall, c_R_en & !x_stall, c_RW_type});
            check("m_addr", m_addr, c_addr);
            check("m_din", m_din, c_din);
        end
        check("c_dout", c_dout, m_dout);

        // memory effect and expected read return
        if (x_gnt && !e_we && rst_n) sb_q.push_back(ref_mem[e_addr[7:0]]);
        if (x_gnt && e_we) ref_mem[e_addr[7:0]] = e_din;
        else if (c_W_en && !x_stall) ref_mem[c_addr[7:0]] = c_din;

        // advance the model
        if (!rst_n) begin
            denied = 0; after_fg = 1'b0;
        end else if (forced) begin
            denied = 0; after_fg = e_req;
        end else if (after_fg) begin
            denied = 0; after_fg = 1'b0;
        end else if (e_req && ca) begin
            denied++;
        end else begin
            denied = 0;
        end
    end

    // Read-return monitor.
    always @(negedge clk) begin
        if (e_rvalid) begin
            if (sb_q.size() == 0) begin
                mismatched++;
                compared++;
                $display("FAIL rvalid_unexpected @%0t: got e_rvalid=1, expected no pending read", $time);
            end else begin
                check("e_rdata", e_rdata, sb_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic core(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        c_W_en = w; c_R_en = r; c_addr = a; c_din = d; c_RW_type = 3'b010;
    endtask

    task automatic ext(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
        e_req = req; e_we = we; e_addr = a; e_din = d; e_RW_type = 3'b010;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic lg, ls;
        bit   busy_mode;
        rst_n = 1'b0;
        core(0, 0, 0, 0);
        ext(0, 0, 0, 0);
        tick(); tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_rvalid", e_rvalid, 0);
        check("rst_rdata", e_rdata, 0);
        check("rst_stall", c_stall, 0);

        // idle core, external read of 0x10
        tick(); ext(1, 0, 32'h10, 0);
        @(negedge clk);
        check("t1_gnt", e_gnt, 1);
        check("t1_stall", c_stall, 0);
        tick(); ext(0, 0, 0, 0);
        @(negedge clk);
        check("t1_rvalid", e_rvalid, 1);
        check("t1_rdata", e_rdata, 32'hDEADBEEF);
        check("t1_stall2", c_stall, 0);

        // core busy every cycle, external read held
        tick(); core(0, 1, 32'h30, 0); ext(1, 0, 32'h10, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t2_gnt", e_gnt, (i == 4));
            check("t2_stall", c_stall, (i == 4));
            if (i == 4) check("t2_m_addr", m_addr, 32'h10);
            if (i == 5) begin
                check("t2_guard_ren", m_R_en, 1);
                check("t2_guard_addr", m_addr, 32'h30);
            end
            tick();
        end
        core(0, 0, 0, 0); ext(0, 0, 0, 0);

        // forced external write colliding with a held core write
        tick(); core(1, 0, 32'h20, 32'hCAFEF00D); ext(1, 1, 32'h20, 32'h12345678);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 4) begin
                check("t3_gnt", e_gnt, 1);
                check("t3_stall", c_stall, 1);
            end
            tick();
        end
        ext(0, 0, 0, 0);
        @(negedge clk);
        check("t3_mem_ext", mem[32], 32'h12345678);
        check("t3_core_wen", m_W_en, 1);
        tick(); core(0, 0, 0, 0);
        @(negedge clk);
        check("t3_mem_core", mem[32], 32'hCAFEF00D);

        // request withdrawn while forced, then a fresh starvation run
        tick(); core(0, 1, 32'h40, 0); ext(1, 0, 32'h44, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t4_denied", e_gnt, 0);
            tick();
        end
        ext(0, 0, 0, 0);
        @(negedge clk);
        check("t4_drop_gnt", e_gnt, 0);
        check("t4_drop_stall", c_stall, 0);
        tick(); ext(1, 0, 32'h44, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_regrant", e_gnt, (i == 4));
            tick();
        end
        ext(0, 0, 0, 0);
        @(negedge clk);
        check("t4_rdata", e_rdata, 32'h0BADF00D);
        tick(); core(0, 0, 0, 0);

        // reset on the forced cycle
        tick(); core(0, 1, 32'h30, 0); ext(1, 0, 32'h10, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tick();
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_rst_stall", c_stall, 0);
        check("t5_rst_gnt", e_gnt, 0);
        tick(); rst_n = 1'b1;
        @(negedge clk);
        check("t5_rvalid", e_rvalid, 0);
        check("t5_rdata", e_rdata, 0);
        check("t5_stall", c_stall, 0);
        tick(); core(0, 0, 0, 0); ext(0, 0, 0, 0);

        // core idle, external request toggling every cycle
        for (int i = 0; i < 8; i++) begin
            tick(); ext((i % 2) == 0, 0, 32'h10 + i, 0);
            @(negedge clk);
            check("t6_gnt", e_gnt, (i % 2) == 0);
        end
        tick(); ext(0, 0, 0, 0);

        // randomized traffic obeying the hold-until-served protocol
        busy_mode = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            lg = e_gnt;
            ls = c_stall;
            tick();
            if ($urandom_range(0, 49) == 0) busy_mode = ~busy_mode;
            rst_n = ($urandom_range(0, 199) != 0);
            if (!ls) begin
                int r;
                r = $urandom_range(0, 9);
                if (r < (busy_mode ? 9 : 3)) begin
                    c_W_en = $urandom_range(0, 1);
                    c_R_en = !c_W_en;
                end else begin
                    c_W_en = 1'b0; c_R_en = 1'b0;
                end
                c_addr = $urandom_range(0, 255);
                c_din = $urandom;
                c_RW_type = 3'($urandom_range(0, 7));
            end
            if (!(e_req && !lg)) begin
                e_req = $urandom_range(0, 1);
                e_we = $urandom_range(0, 1);
                e_addr = $urandom_range(0, 255);
                e_din = $urandom;
                e_RW_type = 3'($urandom_range(0, 7));
            end
        end
        tick(); rst_n = 1'b1; core(0, 0, 0, 0); ext(0, 0, 0, 0);
        tick(); tick();
        @(negedge clk);
        check("sb_drain", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
